lsu_axi_lite_master: RTL and testbench

// - AXI4-Lite initiator (master) for the core's load/store unit; the requester that drives CLINT, UART, SRAM slaves.
// - Accepts one core memory request at a time and runs exactly one AXI4-Lite read (AR/R) or write (AW/W/B) transaction.
// - Aligns sub-word data both ways and returns a single-cycle response pulse to the core.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_if.sv | 41 ++++
 rtl/lsu_data_align.sv | 48 ++++
 rtl/lsu_axi_lite_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_axi_lite_master.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the LSU AXI4-Lite initiator: bus response codes, access sizes and FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with initiator and target views.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU: store replication/strobes, load extract/extend, misalign detect.
module lsu_data_align
  import axi_lite_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = load_data >> {addr_lo, 3'b000};

  always_comb begin
    wdata     = store_data;
    wstrb     = 4'b0000;
    rdata_ext = load_data;
    misalign  = 1'b1;
    case (size)
      SZ_B: begin
        misalign  = 1'b0;
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        wdata     = {2{store_data[15:0]}};
        wstrb     = 4'b0011 << addr_lo;
        rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misalign  = (addr_lo != 2'b00);
        wdata     = store_data;
        wstrb     = 4'b1111;
        rdata_ext = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// LSU AXI4-Lite initiator: one core request becomes exactly one AR/R or AW/W/B transaction.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a core request
// RD_ADDR | arvalid held until arready
// RD_DATA | rready held until rvalid
// WR_REQ  | awvalid/wvalid each held until their own handshake
// WR_RESP | bready held until bvalid
// RESP    | one-cycle resp_valid pulse back to the core
module lsu_axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  axi_lite_if.master        m
);

  lsu_state_t        state;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;

  logic [1:0]  sel_addr_lo, sel_size;
  logic        sel_signed;
  logic [31:0] al_wdata, al_rdata;
  logic [3:0]  al_wstrb;
  logic        al_misalign;
  logic        aw_done_nxt, w_done_nxt;

  // Store path aligns the live request; load path uses the latched request.
  assign sel_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign sel_size    = (state == IDLE) ? req_size      : size_q;
  assign sel_signed  = (state == IDLE) ? req_signed    : signed_q;

  lsu_data_align u_align (
    .addr_lo    (sel_addr_lo),
    .size       (sel_size),
    .sgn        (sel_signed),
    .store_data (req_wdata),
    .load_data  (m.rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .rdata_ext  (al_rdata),
    .misalign   (al_misalign)
  );

  assign aw_done_nxt = !awvalid_q || m.awready;
  assign w_done_nxt  = !wvalid_q  || m.wready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_lo_q  <= 2'b00;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q  <= req_addr[1:0];
            size_q     <= req_size;
            signed_q   <= req_signed;
            resp_rdata <= '0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            if (al_misalign) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (req_wen) begin
              awaddr_q  <= req_addr;
              wdata_q   <= al_wdata;
              wstrb_q   <= al_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              araddr_q  <= req_addr;
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m.rvalid) begin
            rready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (m.rresp != OKAY);
            resp_rdata <= (m.rresp == OKAY) ? al_rdata : '0;
            state      <= RESP;
          end
        end
        WR_REQ: begin
          if (awvalid_q && m.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m.wready)   wvalid_q  <= 1'b0;
          if (aw_done_nxt && w_done_nxt) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m.bvalid) begin
            bready_q   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (m.bresp != OKAY);
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);

  assign m.araddr  = araddr_q;
  assign m.arprot  = 3'b000;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;
  assign m.awaddr  = awaddr_q;
  assign m.awprot  = 3'b000;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Directed bench for lsu_axi_lite_master with a hand-driven AXI4-Lite target.
module tb_lsu_axi_lite_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          cmp = 0;
  int          errs = 0;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;

  axi_lite_if axi ();

  lsu_axi_lite_master dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .m(axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi.arvalid && axi.arready) ar_hs++;
    if (axi.awvalid && axi.awready) aw_hs++;
    if (axi.wvalid && axi.wready)   w_hs++;
    if (axi.bvalid && axi.bready)   b_hs++;
  end

  // Zero-wait read: AR accepted at c1, R presented at c2, response expected at c3.
  task automatic run_read(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [31:0] rd, input logic [1:0] rr,
                          output logic arv, output logic [31:0] ara, output logic v_early,
                          output logic v, output logic [31:0] d, output logic e,
                          output logic v_late, output logic rdy);
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = a; req_size = sz; req_signed = sg;
    axi.arready = 1;
    @(negedge clk);
    req_valid = 0; arv = axi.arvalid; ara = axi.araddr;
    @(negedge clk);
    v_early = resp_valid; axi.rvalid = 1; axi.rdata = rd; axi.rresp = rr;
    @(negedge clk);
    v = resp_valid; d = resp_rdata; e = resp_err;
    axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    @(negedge clk);
    v_late = resp_valid; rdy = req_ready;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input logic [1:0] br,
                           output logic awv, output logic wv, output logic [31:0] awa,
                           output logic [31:0] wdt, output logic [3:0] ws, output logic [31:0] ara,
                           output logic v, output logic e, output logic [31:0] d);
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = a; req_size = sz; req_wdata = wd;
    axi.awready = 1; axi.wready = 1;
    @(negedge clk);
    req_valid = 0; awv = axi.awvalid; wv = axi.wvalid; awa = axi.awaddr;
    wdt = axi.wdata; ws = axi.wstrb; ara = axi.araddr;
    @(negedge clk);
    axi.bvalid = 1; axi.bresp = br;
    @(negedge clk);
    v = resp_valid; e = resp_err; d = resp_rdata;
    axi.bvalid = 0; axi.bresp = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    #1 reset_n = 0;
    #1;
    cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
      errs++; $display("FAIL reset_valids: got %b want 00000",
                       {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
    cmp++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/0/0", resp_valid, resp_err, resp_rdata); end
    cmp++; if (req_ready !== 1'b1) begin
      errs++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    repeat (3) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_load_word();
    logic arv, ve, v, e, vl, rdy; logic [31:0] ara, d; int ar0;
    ar0 = ar_hs;
    run_read(32'ha000_0048, 2'd2, 1'b0, 32'h0000_1234, 2'b00, arv, ara, ve, v, d, e, vl, rdy);
    cmp++; if (arv !== 1'b1 || ara !== 32'ha000_0048) begin
      errs++; $display("FAIL lw_ar: got arvalid=%b araddr=%h want 1/a0000048", arv, ara); end
    cmp++; if (ve !== 1'b0 || v !== 1'b1 || vl !== 1'b0) begin
      errs++; $display("FAIL lw_latency: got c2=%b c3=%b c4=%b want 0/1/0", ve, v, vl); end
    cmp++; if (d !== 32'h0000_1234 || e !== 1'b0) begin
      errs++; $display("FAIL lw_data: got %h err=%b want 00001234/0", d, e); end
    cmp++; if (rdy !== 1'b1 || ar_hs - ar0 !== 1) begin
      errs++; $display("FAIL lw_count: got ready=%b ar=%0d want 1/1", rdy, ar_hs - ar0); end
  endtask

  task automatic test_store_align();
    logic awv, wv, v, e; logic [31:0] awa, wdt, ara, d; logic [3:0] ws; int b0;
    b0 = b_hs;
    run_write(32'h8000_0003, 2'd0, 32'h0000_00AB, 2'b00, awv, wv, awa, wdt, ws, ara, v, e, d);
    cmp++; if (awv !== 1'b1 || wv !== 1'b1 || awa !== 32'h8000_0003) begin
      errs++; $display("FAIL sb_valid: got aw=%b w=%b awaddr=%h want 1/1/80000003", awv, wv, awa); end
    cmp++; if (ws !== 4'b1000 || wdt !== 32'hABAB_ABAB) begin
      errs++; $display("FAIL sb_lanes: got wstrb=%b wdata=%h want 1000/abababab", ws, wdt); end
    cmp++; if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0 || ara !== 32'h0) begin
      errs++; $display("FAIL sb_resp: got v=%b e=%b d=%h araddr=%h want 1/0/0/0", v, e, d, ara); end
    cmp++; if (b_hs - b0 !== 1) begin
      errs++; $display("FAIL sb_bcount: got %0d want 1", b_hs - b0); end
    run_write(32'h8000_0002, 2'd1, 32'h1234_BEEF, 2'b00, awv, wv, awa, wdt, ws, ara, v, e, d);
    cmp++; if (ws !== 4'b1100 || wdt !== 32'hBEEF_BEEF || v !== 1'b1) begin
      errs++; $display("FAIL sh_lanes: got wstrb=%b wdata=%h v=%b want 1100/beefbeef/1", ws, wdt, v); end
    run_write(32'ha000_4000, 2'd2, 32'hCAFE_F00D, 2'b10, awv, wv, awa, wdt, ws, ara, v, e, d);
    cmp++; if (ws !== 4'b1111 || wdt !== 32'hCAFE_F00D || v !== 1'b1 || e !== 1'b1) begin
      errs++; $display("FAIL sw_slverr: got wstrb=%b wdata=%h v=%b e=%b want 1111/cafef00d/1/1", ws, wdt, v, e); end
  endtask

  task automatic test_split_write();
    int b0, aw0, w0;
    b0 = b_hs; aw0 = aw_hs; w0 = w_hs;
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010; req_size = 2'd2; req_wdata = 32'h1122_3344;
    axi.awready = 1; axi.wready = 0;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) axi.wready = 1;
      cmp++; if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b1 || axi.wdata !== 32'h1122_3344 || axi.wstrb !== 4'b1111) begin
        errs++; $display("FAIL split_hold[%0d]: got aw=%b w=%b wdata=%h wstrb=%b want 0/1/11223344/1111",
                         i, axi.awvalid, axi.wvalid, axi.wdata, axi.wstrb); end
    end
    @(negedge clk);
    cmp++; if (axi.wvalid !== 1'b0 || axi.bready !== 1'b1 || resp_valid !== 1'b0) begin
      errs++; $display("FAIL split_wdone: got w=%b bready=%b v=%b want 0/1/0", axi.wvalid, axi.bready, resp_valid); end
    axi.bvalid = 1; axi.bresp = 2'b00;
    @(negedge clk);
    axi.bvalid = 0;
    cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || axi.bready !== 1'b0) begin
      errs++; $display("FAIL split_resp: got v=%b e=%b bready=%b want 1/0/0", resp_valid, resp_err, axi.bready); end
    @(negedge clk);
    cmp++; if (b_hs - b0 !== 1 || aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
      errs++; $display("FAIL split_counts: got aw=%0d w=%0d b=%0d want 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
  endtask

  task automatic test_load_align();
    logic arv, ve, v, e, vl, rdy; logic [31:0] ara, d;
    logic [31:0] addr_t [6] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0004};
    logic [1:0]  size_t [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    logic        sgn_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] rd_t   [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h0000_FFFE, 32'h0000_7F00, 32'hDEAD_BEEF};
    logic [1:0]  rr_t   [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [31:0] exp_d  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_FFFE, 32'h0000_007F, 32'h0};
    logic        exp_e  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_read(addr_t[i], size_t[i], sgn_t[i], rd_t[i], rr_t[i], arv, ara, ve, v, d, e, vl, rdy);
      cmp++; if (v !== 1'b1 || d !== exp_d[i] || e !== exp_e[i] || ara !== addr_t[i]) begin
        errs++; $display("FAIL load_align[%0d]: got v=%b d=%h e=%b araddr=%h want 1/%h/%b/%h",
                         i, v, d, e, ara, exp_d[i], exp_e[i], addr_t[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addr_t [3] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0000};
    logic [1:0]  size_t [3] = '{2'd1, 2'd2, 2'd3};
    int ar0, aw0;
    ar0 = ar_hs; aw0 = aw_hs;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1; req_wen = (i == 2); req_addr = addr_t[i]; req_size = size_t[i];
      axi.arready = 1; axi.awready = 1;
      @(negedge clk);
      req_valid = 0;
      cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0) begin
        errs++; $display("FAIL misalign[%0d]: got v=%b e=%b d=%h ar=%b aw=%b want 1/1/0/0/0",
                         i, resp_valid, resp_err, resp_rdata, axi.arvalid, axi.awvalid); end
      @(negedge clk);
      cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errs++; $display("FAIL misalign_done[%0d]: got v=%b ready=%b want 0/1", i, resp_valid, req_ready); end
    end
    cmp++; if (ar_hs - ar0 !== 0 || aw_hs - aw0 !== 0) begin
      errs++; $display("FAIL misalign_nobus: got ar=%0d aw=%0d want 0/0", ar_hs - ar0, aw_hs - aw0); end
  endtask

  task automatic test_reset_mid();
    logic arv, ve, v, e, vl, rdy; logic [31:0] ara, d;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0100; req_size = 2'd2; axi.arready = 0;
    @(negedge clk);
    req_valid = 0;
    cmp++; if (axi.arvalid !== 1'b1) begin
      errs++; $display("FAIL rst_mid_pre: got arvalid=%b want 1", axi.arvalid); end
    #2 reset_n = 0;
    #1;
    cmp++; if (axi.arvalid !== 1'b0 || req_ready !== 1'b1) begin
      errs++; $display("FAIL rst_mid_async: got arvalid=%b ready=%b want 0/1", axi.arvalid, req_ready); end
    @(negedge clk);
    reset_n = 1;
    run_read(32'h8000_0104, 2'd2, 1'b0, 32'h5566_7788, 2'b00, arv, ara, ve, v, d, e, vl, rdy);
    cmp++; if (v !== 1'b1 || d !== 32'h5566_7788 || e !== 1'b0 || rdy !== 1'b1) begin
      errs++; $display("FAIL rst_mid_recover: got v=%b d=%h e=%b ready=%b want 1/55667788/0/1", v, d, e, rdy); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_align();
    test_split_write();
    test_load_align();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
